// File: rtl/prog_cnt_pkg.sv
// Shared definitions for the programmable down-counter: operation select
// encoding and the per-cycle command priority encoder.
package prog_cnt_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_LOAD = 2'd1,
        OP_DEC  = 2'd2,
        OP_DIV  = 2'd3
    } op_e;

    // load bypasses the enable; dec wins over div when both are requested
    function automatic op_e op_select(input logic en, input logic load,
                                      input logic dec, input logic div);
        if (load)
            return OP_LOAD;
        else if (!en)
            return OP_IDLE;
        else if (dec)
            return OP_DEC;
        else if (div)
            return OP_DIV;
        else
            return OP_IDLE;
    endfunction

endpackage

// File: rtl/prog_cnt_next.sv
// Combinational next-count and pulse calculator: step clamp, saturate or
// reload at zero, and logical barrel shift for divide.
module prog_cnt_next
    import prog_cnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int SHIFT_W = 3
) (
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   count_q,
    input  logic [WIDTH-1:0]   reload_q,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [STEP_W-1:0]  step,
    input  logic [SHIFT_W-1:0] div_shift,
    input  logic               auto_reload,
    output logic [WIDTH-1:0]   count_d,
    output logic               tc_d,
    output logic               sat_d
);

    // compare in a width that holds both operands so a wide step never truncates
    localparam int CW = (WIDTH > STEP_W) ? WIDTH : STEP_W;

    logic [CW-1:0] cnt_ext;
    logic [CW-1:0] step_ext;
    logic [CW-1:0] diff;

    always_comb begin
        cnt_ext  = CW'(count_q);
        step_ext = (step == '0) ? CW'(1) : CW'(step);
        diff     = cnt_ext - step_ext;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        sat_d   = 1'b0;
        case (op)
            OP_LOAD: count_d = load_val;
            OP_DEC: begin
                if (cnt_ext > step_ext) begin
                    count_d = diff[WIDTH-1:0];
                end else if (auto_reload) begin
                    count_d = reload_q;
                    tc_d    = 1'b1;
                end else begin
                    count_d = '0;
                    tc_d    = (count_q != '0);
                    sat_d   = (count_q == '0);
                end
            end
            OP_DIV: begin
                if (int'(div_shift) >= WIDTH)
                    count_d = '0;
                else
                    count_d = count_q >> div_shift;
            end
            default: count_d = count_q;
        endcase
    end

endmodule

// File: rtl/prog_down_counter.sv
// Programmable down-counter with load, variable-step decrement, shift-divide
// and auto-reload; all outputs registered.
module prog_down_counter
    import prog_cnt_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int SHIFT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               dec,
    input  logic [STEP_W-1:0]  step,
    input  logic               div,
    input  logic [SHIFT_W-1:0] div_shift,
    input  logic               auto_reload,
    output logic [WIDTH-1:0]   count,
    output logic               zero,
    output logic               tc_pulse,
    output logic               sat
);

    op_e              op;
    logic [WIDTH-1:0] count_d, count_q;
    logic [WIDTH-1:0] reload_d, reload_q;
    logic             zero_d, zero_q;
    logic             tc_d, tc_q;
    logic             sat_d, sat_q;

    assign op = op_select(en, load, dec, div);

    prog_cnt_next #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .SHIFT_W (SHIFT_W)
    ) u_next (
        .op          (op),
        .count_q     (count_q),
        .reload_q    (reload_q),
        .load_val    (load_val),
        .step        (step),
        .div_shift   (div_shift),
        .auto_reload (auto_reload),
        .count_d     (count_d),
        .tc_d        (tc_d),
        .sat_d       (sat_d)
    );

    // zero is derived from the next count so it never lags count
    always_comb begin
        reload_d = (op == OP_LOAD) ? load_val : reload_q;
        zero_d   = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
            zero_q   <= 1'b1;
            tc_q     <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            zero_q   <= zero_d;
            tc_q     <= tc_d;
            sat_q    <= sat_d;
        end
    end

    assign count    = count_q;
    assign zero     = zero_q;
    assign tc_pulse = tc_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_prog_down_counter.sv
// Bench for prog_down_counter: directed scenarios on an 8-bit and a 16-bit
// instance, then randomized traffic against a behavioural reference model.
module tb_prog_down_counter;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance (default parameters)
    logic        a_rst, a_en, a_load, a_dec, a_div, a_ar;
    logic [7:0]  a_lv;
    logic [3:0]  a_step;
    logic [2:0]  a_sh;
    logic [7:0]  a_count;
    logic        a_zero, a_tc, a_sat;

    // 16-bit instance, shift range reaching past WIDTH
    logic        b_rst, b_en, b_load, b_dec, b_div, b_ar;
    logic [15:0] b_lv;
    logic [7:0]  b_step;
    logic [4:0]  b_sh;
    logic [15:0] b_count;
    logic        b_zero, b_tc, b_sat;

    prog_down_counter u_dut_a (
        .clk (clk), .rst (a_rst), .en (a_en), .load (a_load), .load_val (a_lv),
        .dec (a_dec), .step (a_step), .div (a_div), .div_shift (a_sh),
        .auto_reload (a_ar), .count (a_count), .zero (a_zero),
        .tc_pulse (a_tc), .sat (a_sat)
    );

    prog_down_counter #(.WIDTH(16), .STEP_W(8), .SHIFT_W(5)) u_dut_b (
        .clk (clk), .rst (b_rst), .en (b_en), .load (b_load), .load_val (b_lv),
        .dec (b_dec), .step (b_step), .div (b_div), .div_shift (b_sh),
        .auto_reload (b_ar), .count (b_count), .zero (b_zero),
        .tc_pulse (b_tc), .sat (b_sat)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // reference model state
    int ma_cnt, ma_rl, mb_cnt, mb_rl;
    bit ma_tc, ma_sat, mb_tc, mb_sat;

    task automatic model_step(input int w, input bit rst, input bit en, input bit load,
                              input int lv, input bit dec, input int stp, input bit div,
                              input int sh, input bit ar,
                              inout int cnt, inout int rl, output bit tc, output bit sat);
        int s;
        tc  = 0;
        sat = 0;
        if (rst) begin
            cnt = 0;
            rl  = 0;
        end else if (load) begin
            cnt = lv;
            rl  = lv;
        end else if (!en) begin
            // hold
        end else if (dec) begin
            s = (stp == 0) ? 1 : stp;
            if (cnt > s) begin
                cnt = cnt - s;
            end else if (cnt != 0) begin
                cnt = ar ? rl : 0;
                tc  = 1;
            end else if (ar) begin
                cnt = rl;
                tc  = 1;
            end else begin
                sat = 1;
            end
        end else if (div) begin
            cnt = (sh >= w) ? 0 : (cnt >> sh);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(8, a_rst, a_en, a_load, int'(a_lv), a_dec, int'(a_step), a_div,
                   int'(a_sh), a_ar, ma_cnt, ma_rl, ma_tc, ma_sat);
        model_step(16, b_rst, b_en, b_load, int'(b_lv), b_dec, int'(b_step), b_div,
                   int'(b_sh), b_ar, mb_cnt, mb_rl, mb_tc, mb_sat);
        @(negedge clk);
        chk("a_count", a_count, ma_cnt);
        chk("a_zero",  a_zero,  (ma_cnt == 0) ? 1 : 0);
        chk("a_tc",    a_tc,    ma_tc);
        chk("a_sat",   a_sat,   ma_sat);
        chk("b_count", b_count, mb_cnt);
        chk("b_zero",  b_zero,  (mb_cnt == 0) ? 1 : 0);
        chk("b_tc",    b_tc,    mb_tc);
        chk("b_sat",   b_sat,   mb_sat);
    endtask

    task automatic a_idle();
        a_rst = 0; a_en = 1; a_load = 0; a_lv = '0; a_dec = 0; a_step = '0;
        a_div = 0; a_sh = '0; a_ar = 0;
    endtask

    task automatic b_idle();
        b_rst = 0; b_en = 1; b_load = 0; b_lv = '0; b_dec = 0; b_step = '0;
        b_div = 0; b_sh = '0; b_ar = 0;
    endtask

    initial begin
        a_idle();
        b_idle();
        ma_cnt = 0; ma_rl = 0; mb_cnt = 0; mb_rl = 0;
        @(negedge clk);

        // reset overrides load and dec
        a_rst = 1; a_load = 1; a_lv = 8'd99; a_dec = 1; b_rst = 1;
        tick();
        chk("rst_count", a_count, 0);
        chk("rst_zero",  a_zero, 1);
        chk("rst_tc",    a_tc, 0);
        chk("rst_sat",   a_sat, 0);
        a_idle();
        b_idle();
        tick();
        chk("rst_hold", a_count, 0);

        // countdown to saturation without auto-reload
        a_load = 1; a_lv = 8'd200;
        tick();
        chk("load200", a_count, 200);
        a_idle();
        a_dec = 1; a_step = 4'd3;
        for (int i = 0; i < 66; i++) tick();
        chk("dec66", a_count, 2);
        tick();
        chk("dec_zero_cnt", a_count, 0);
        chk("dec_zero_z",   a_zero, 1);
        chk("dec_zero_tc",  a_tc, 1);
        tick();
        chk("sat_pulse", a_sat, 1);
        chk("sat_tc",    a_tc, 0);
        chk("sat_cnt",   a_count, 0);
        a_idle();
        tick();
        chk("sat_clear", a_sat, 0);

        // auto-reload periodic
        a_load = 1; a_lv = 8'd5;
        tick();
        a_idle();
        a_ar = 1; a_dec = 1; a_step = 4'd2;
        for (int p = 0; p < 2; p++) begin
            tick(); chk("ar_3", a_count, 3); chk("ar_tc0", a_tc, 0);
            tick(); chk("ar_1", a_count, 1);
            tick(); chk("ar_5", a_count, 5); chk("ar_tc1", a_tc, 1);
        end

        // priority: load over dec/div, dec over div
        a_idle();
        a_load = 1; a_dec = 1; a_div = 1; a_lv = 8'd17; a_sh = 3'd1;
        tick();
        chk("prio_load", a_count, 17);
        a_idle();
        a_dec = 1; a_div = 1; a_step = 4'd0; a_sh = 3'd2;
        tick();
        chk("prio_dec", a_count, 16);

        // divide and enable gating
        a_idle();
        a_load = 1; a_lv = 8'hB4;
        tick();
        a_idle();
        a_div = 1; a_sh = 3'd2;
        tick();
        chk("div2", a_count, 8'h2D);
        a_sh = 3'd7;
        tick();
        chk("div7", a_count, 0);
        chk("div7_tc", a_tc, 0);
        a_idle();
        a_load = 1; a_lv = 8'd50;
        tick();
        a_idle();
        a_en = 0; a_dec = 1;
        tick();
        chk("en0_hold", a_count, 50);
        a_dec = 0; a_load = 1; a_lv = 8'd9;
        tick();
        chk("en0_load", a_count, 9);

        // reset mid-countdown loses the reload value
        a_idle();
        a_rst = 1;
        tick();
        a_idle();
        a_ar = 1; a_dec = 1; a_step = 4'd1;
        tick();
        chk("rl0_cnt", a_count, 0);
        chk("rl0_tc",  a_tc, 1);
        a_idle();

        // 16-bit wide step
        b_load = 1; b_lv = 16'h0100;
        tick();
        b_idle();
        b_dec = 1; b_step = 8'hFF;
        tick();
        chk("w16_dec", b_count, 1);
        tick();
        chk("w16_zero", b_count, 0);
        chk("w16_tc",   b_tc, 1);
        b_idle();
        b_load = 1; b_lv = 16'hFFFF;
        tick();
        b_idle();
        b_div = 1; b_sh = 5'd20;
        tick();
        chk("w16_div_wide", b_count, 0);
        b_idle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            a_rst  = ($urandom_range(0, 49) == 0);
            a_en   = ($urandom_range(0, 7) != 0);
            a_load = ($urandom_range(0, 9) == 0);
            a_lv   = 8'($urandom);
            a_dec  = ($urandom_range(0, 1) == 1);
            a_step = 4'($urandom);
            a_div  = ($urandom_range(0, 3) == 0);
            a_sh   = 3'($urandom);
            a_ar   = ($urandom_range(0, 2) == 0);
            b_rst  = ($urandom_range(0, 49) == 0);
            b_en   = ($urandom_range(0, 7) != 0);
            b_load = ($urandom_range(0, 9) == 0);
            b_lv   = 16'($urandom_range(0, 1023));
            b_dec  = ($urandom_range(0, 1) == 1);
            b_step = 8'($urandom);
            b_div  = ($urandom_range(0, 5) == 0);
            b_sh   = 5'($urandom);
            b_ar   = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
